tone_sequencer: RTL and testbench

//  Sequencer driving the square-wave tone generator: plays a stored list of notes, each a

---
 rtl/tone_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_tone_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Tone sequencer: plays a stored note table (threshold + duration) into the square-wave generator.
// Latency: start accepted on the clock edge; FETCH is 1 cycle, then PLAY/GAP last dur/GAP_TICKS ticks.
// No backpressure: stop aborts to IDLE next cycle; optional TONE_SEQ_LOOP_EN repeats the list until stop.
module tone_sequencer #(
  parameter int THRESH_W  = 32,
  parameter int DUR_W     = 8,
  parameter int ADDR_W    = 4,
  parameter int TICK_DIV  = 24000,
  parameter int GAP_TICKS = 10
) (
  input  logic                int_osc,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [ADDR_W:0]     seq_len,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [THRESH_W-1:0] wr_thresh,
  input  logic [DUR_W-1:0]    wr_dur,
  output logic                tone_en,
  output logic [THRESH_W-1:0] tone_thresh,
  output logic                note_strobe,
  output logic [ADDR_W-1:0]   note_idx,
  output logic                busy,
  output logic                done
);

`ifdef TONE_SEQ_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LEN_W = ADDR_W + 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam int TK_W  = (DUR_W > GAP_W) ? DUR_W : GAP_W;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
  localparam logic [TK_W-1:0]   TK_ONE   = TK_W'(1);
  localparam logic [TK_W-1:0]   GAP_LAST = TK_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [THRESH_W-1:0] thr_q, thr_d;
  logic [DUR_W-1:0]    dur_q, dur_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [TK_W-1:0]     tk_q, tk_d;

  // Note table; contents deliberately survive reset.
  logic [THRESH_W-1:0] thr_mem [DEPTH];
  logic [DUR_W-1:0]    dur_mem [DEPTH];

  logic [THRESH_W-1:0] rd_thr;
  logic [DUR_W-1:0]    rd_dur;
  logic                is_last;
  logic                tick_end;
  state_t              adv_state;
  logic [ADDR_W-1:0]   adv_idx;

  assign rd_thr   = thr_mem[idx_q];
  assign rd_dur   = dur_mem[idx_q];
  assign is_last  = ({1'b0, idx_q} + LEN_ONE) == len_q;
  assign tick_end = (div_q == DIV_LAST);

  // Table writes are only honoured while idle so playback never sees a half-updated entry.
  always_ff @(posedge int_osc) begin
    if (wr_en && (state_q == S_IDLE)) begin
      thr_mem[wr_addr] <= wr_thresh;
      dur_mem[wr_addr] <= wr_dur;
    end
  end

  // Where to go once the current note (or skipped note) is finished.
  always_comb begin
    adv_state = S_FETCH;
    adv_idx   = idx_q + IDX_ONE;
    if (is_last) begin
      if (LOOP_EN) begin
        adv_state = S_FETCH;
        adv_idx   = '0;
      end else begin
        adv_state = S_FIN;
        adv_idx   = idx_q;
      end
    end
  end

  // Next-state and datapath update; stop overrides everything outside IDLE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    thr_d   = thr_q;
    dur_d   = dur_q;
    div_d   = div_q;
    tk_d    = tk_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          len_d   = seq_len;
          idx_d   = '0;
          state_d = (seq_len == '0) ? S_FIN : S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_dur == '0) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end else begin
          thr_d   = rd_thr;
          dur_d   = rd_dur;
          div_d   = '0;
          tk_d    = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick_end) begin
          div_d = '0;
          tk_d  = tk_q + TK_ONE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
        if (tick_end && ((tk_q + TK_ONE) == TK_W'(dur_q))) begin
          if (GAP_TICKS > 0) begin
            state_d = S_GAP;
            div_d   = '0;
            tk_d    = '0;
          end else begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end
      end
      S_GAP: begin
        if (tick_end) begin
          div_d = '0;
          tk_d  = tk_q + TK_ONE;
        end else begin
          div_d = div_q + DIV_ONE;
        end
        if (tick_end && (tk_q == GAP_LAST)) begin
          state_d = adv_state;
          idx_d   = adv_idx;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      thr_d   = thr_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge int_osc or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      thr_q   <= '0;
      dur_q   <= '0;
      div_q   <= '0;
      tk_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      thr_q   <= thr_d;
      dur_q   <= dur_d;
      div_q   <= div_d;
      tk_q    <= tk_d;
    end
  end

  // Counters are cleared on PLAY entry, so 0/0 in PLAY marks its first cycle.
  assign note_strobe = (state_q == S_PLAY) && (div_q == '0) && (tk_q == '0);
  assign tone_en     = (state_q == S_PLAY) && (thr_q != '0);
  assign tone_thresh = thr_q;
  assign note_idx    = idx_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_FIN);

endmodule

// File: tb/tb_tone_sequencer.sv
module tb_tone_sequencer;
  localparam int TW = 32;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          int_osc = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW:0]   seq_len = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [TW-1:0] wr_thresh = '0;
  logic [DW-1:0] wr_dur = '0;
  logic          tone_en;
  logic [TW-1:0] tone_thresh;
  logic          note_strobe;
  logic [AW-1:0] note_idx;
  logic          busy;
  logic          done;

  int total = 0;
  int bad = 0;

  logic          tr_en [64];
  logic [TW-1:0] tr_th [64];
  logic          tr_st [64];
  logic          tr_dn [64];
  logic          tr_bz [64];
  logic [AW-1:0] tr_ix [64];

  tone_sequencer #(
    .THRESH_W(TW), .DUR_W(DW), .ADDR_W(AW), .TICK_DIV(4), .GAP_TICKS(1)
  ) dut (
    .int_osc(int_osc), .reset(reset), .start(start), .stop(stop), .seq_len(seq_len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_thresh(wr_thresh), .wr_dur(wr_dur),
    .tone_en(tone_en), .tone_thresh(tone_thresh), .note_strobe(note_strobe),
    .note_idx(note_idx), .busy(busy), .done(done)
  );

  always #5 int_osc = ~int_osc;

  task automatic step();
    @(posedge int_osc);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [TW-1:0] t, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_thresh = t; wr_dur = d;
    step();
    wr_en = 1'b0;
  endtask

  // Start a sequence and record outputs; index k = cycle after the k-th edge (k=1 is the accept edge).
  task automatic run(input int len, input int n);
    seq_len = len[AW:0];
    start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (k == 1) start = 1'b0;
      tr_en[k] = tone_en; tr_th[k] = tone_thresh; tr_st[k] = note_strobe;
      tr_dn[k] = done;    tr_bz[k] = busy;        tr_ix[k] = note_idx;
    end
  endtask

  task automatic test_reset();
    int nz;
    #2 reset = 1'b1;
    step(); step();
    total++; if (tone_en !== 1'b0) begin bad++; $display("FAIL reset_tone_en got=%0b want=0", tone_en); end
    total++; if (tone_thresh !== '0) begin bad++; $display("FAIL reset_thresh got=%0d want=0", tone_thresh); end
    total++; if (note_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%0b want=0", note_strobe); end
    total++; if (note_idx !== '0) begin bad++; $display("FAIL reset_idx got=%0d want=0", note_idx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", done); end
    reset = 1'b0;
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (busy !== 1'b0 || tone_en !== 1'b0 || done !== 1'b0 || note_strobe !== 1'b0) nz++;
    end
    total++; if (nz !== 0) begin bad++; $display("FAIL idle_hold active_cycles got=%0d want=0", nz); end
  endtask

  task automatic test_play();
    int e100, e200, e300, nst, ndn, egap;
    wr(0, 100, 2); wr(1, 200, 1); wr(2, 300, 3);
    run(3, 45);
    e100 = 0; e200 = 0; e300 = 0; nst = 0; ndn = 0; egap = 0;
    for (int k = 1; k <= 45; k++) begin
      if (tr_en[k] === 1'b1 && tr_th[k] == 100) e100++;
      if (tr_en[k] === 1'b1 && tr_th[k] == 200) e200++;
      if (tr_en[k] === 1'b1 && tr_th[k] == 300) e300++;
      if (tr_st[k] === 1'b1) nst++;
      if (tr_dn[k] === 1'b1) ndn++;
      if (k >= 10 && k <= 13 && tr_en[k] !== 1'b0) egap++;
    end
    total++; if (e100 !== 8) begin bad++; $display("FAIL play_en100 got=%0d want=8", e100); end
    total++; if (e200 !== 4) begin bad++; $display("FAIL play_en200 got=%0d want=4", e200); end
    total++; if (e300 !== 12) begin bad++; $display("FAIL play_en300 got=%0d want=12", e300); end
    total++; if (nst !== 3) begin bad++; $display("FAIL play_strobes got=%0d want=3", nst); end
    total++; if ({tr_st[2], tr_st[15], tr_st[24]} !== 3'b111) begin bad++; $display("FAIL play_strobe_pos got=%b want=111", {tr_st[2], tr_st[15], tr_st[24]}); end
    total++; if (egap !== 0) begin bad++; $display("FAIL play_gap_silent got=%0d want=0", egap); end
    total++; if (tr_ix[15] !== 4'd1 || tr_ix[24] !== 4'd2) begin bad++; $display("FAIL play_idx got=%0d,%0d want=1,2", tr_ix[15], tr_ix[24]); end
    total++; if (ndn !== 1 || tr_dn[40] !== 1'b1) begin bad++; $display("FAIL play_done got=%0d@40=%0b want=1@40=1", ndn, tr_dn[40]); end
    total++; if (tr_bz[40] !== 1'b1 || tr_bz[41] !== 1'b0) begin bad++; $display("FAIL play_busy_drop got=%0b%0b want=10", tr_bz[40], tr_bz[41]); end
    total++; if (tr_th[41] !== 32'd300) begin bad++; $display("FAIL play_thresh_kept got=%0d want=300", tr_th[41]); end
  endtask

  task automatic test_rest_skip();
    int nst, nen, saw50;
    wr(0, 0, 2); wr(1, 50, 0); wr(2, 70, 1);
    run(3, 30);
    nst = 0; nen = 0; saw50 = 0;
    for (int k = 1; k <= 30; k++) begin
      if (tr_st[k] === 1'b1) nst++;
      if (tr_en[k] === 1'b1) nen++;
      if (tr_th[k] == 50) saw50++;
    end
    total++; if (nst !== 2) begin bad++; $display("FAIL rest_strobes got=%0d want=2", nst); end
    total++; if (tr_st[2] !== 1'b1 || tr_st[16] !== 1'b1) begin bad++; $display("FAIL rest_strobe_pos got=%0b%0b want=11", tr_st[2], tr_st[16]); end
    total++; if (nen !== 4) begin bad++; $display("FAIL rest_en_cycles got=%0d want=4", nen); end
    total++; if (saw50 !== 0) begin bad++; $display("FAIL skip_thresh50 got=%0d want=0", saw50); end
    total++; if (tr_ix[16] !== 4'd2) begin bad++; $display("FAIL skip_idx got=%0d want=2", tr_ix[16]); end
    total++; if (tr_dn[24] !== 1'b1 || tr_bz[25] !== 1'b0) begin bad++; $display("FAIL rest_done got=%0b%0b want=10", tr_dn[24], tr_bz[25]); end
  endtask

  task automatic test_stop();
    int ndn;
    wr(0, 100, 2); wr(1, 200, 1); wr(2, 300, 3);
    seq_len = 3; start = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step();
      if (k == 1) start = 1'b0;
    end
    total++; if (tone_en !== 1'b1 || tone_thresh !== 32'd200) begin bad++; $display("FAIL stop_pre got=%0b/%0d want=1/200", tone_en, tone_thresh); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (tone_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stop_idle got=en%0b busy%0b done%0b want=000", tone_en, busy, done); end
    total++; if (note_idx !== 4'd1) begin bad++; $display("FAIL stop_idx_held got=%0d want=1", note_idx); end
    ndn = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) ndn++;
    end
    total++; if (ndn !== 0) begin bad++; $display("FAIL stop_quiet got=%0d want=0", ndn); end
    wr(0, 555, 1);
    run(1, 12);
    total++; if (tr_th[2] !== 32'd555 || tr_st[2] !== 1'b1) begin bad++; $display("FAIL stop_write_taken got=%0d want=555", tr_th[2]); end
    total++; if (tr_dn[10] !== 1'b1) begin bad++; $display("FAIL single_done got=%0b want=1", tr_dn[10]); end
  endtask

  task automatic test_write_while_busy();
    int nen;
    seq_len = 1; start = 1'b1;
    step(); start = 1'b0;
    step();
    wr_en = 1'b1; wr_addr = 0; wr_thresh = 999; wr_dur = 2;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 10; i++) step();
    run(1, 12);
    nen = 0;
    for (int k = 1; k <= 12; k++) if (tr_en[k] === 1'b1) nen++;
    total++; if (tr_th[2] !== 32'd555) begin bad++; $display("FAIL busy_write_thresh got=%0d want=555", tr_th[2]); end
    total++; if (nen !== 4) begin bad++; $display("FAIL busy_write_dur got=%0d want=4", nen); end
  endtask

  task automatic test_len0();
    int ndn, act;
    seq_len = 0; start = 1'b1;
    ndn = 0; act = 0;
    for (int k = 1; k <= 3; k++) begin
      step();
      if (k == 1) start = 1'b0;
      if (done === 1'b1) ndn++;
      if (tone_en !== 1'b0 || note_strobe !== 1'b0) act++;
    end
    total++; if (ndn !== 1) begin bad++; $display("FAIL len0_done got=%0d want=1", ndn); end
    total++; if (busy !== 1'b0 || act !== 0) begin bad++; $display("FAIL len0_idle got=busy%0b act%0d want=0/0", busy, act); end
  endtask

  task automatic test_async_reset();
    wr(0, 555, 1);
    seq_len = 1; start = 1'b1;
    step(); start = 1'b0;
    step(); step();
    total++; if (tone_en !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0b want=1", tone_en); end
    #3 reset = 1'b1;
    #1;
    total++; if (tone_en !== 1'b0 || busy !== 1'b0 || tone_thresh !== '0 || note_idx !== '0) begin
      bad++; $display("FAIL arst_immediate got=en%0b busy%0b th%0d idx%0d want=0000", tone_en, busy, tone_thresh, note_idx);
    end
    step();
    reset = 1'b0;
    step();
    run(1, 12);
    total++; if (tr_th[2] !== 32'd555) begin bad++; $display("FAIL arst_table_kept got=%0d want=555", tr_th[2]); end
  endtask

`ifdef TONE_SEQ_LOOP_EN
  task automatic test_loop();
    int ndn;
    wr(0, 11, 1); wr(1, 22, 1);
    run(2, 40);
    ndn = 0;
    for (int k = 1; k <= 40; k++) if (tr_dn[k] === 1'b1) ndn++;
    total++; if (tr_ix[11] !== 4'd1 || tr_th[11] !== 32'd22) begin bad++; $display("FAIL loop_second got=%0d/%0d want=1/22", tr_ix[11], tr_th[11]); end
    total++; if (tr_ix[20] !== 4'd0 || tr_th[20] !== 32'd11 || tr_st[20] !== 1'b1) begin bad++; $display("FAIL loop_wrap got=%0d/%0d want=0/11", tr_ix[20], tr_th[20]); end
    total++; if (tr_ix[29] !== 4'd1 || tr_st[29] !== 1'b1) begin bad++; $display("FAIL loop_again got=%0d want=1", tr_ix[29]); end
    total++; if (ndn !== 0 || tr_bz[40] !== 1'b1) begin bad++; $display("FAIL loop_nodone got=%0d/%0b want=0/1", ndn, tr_bz[40]); end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL loop_stop got=%0b%0b want=00", busy, done); end
  endtask
`endif

  initial begin
    test_reset();
`ifdef TONE_SEQ_LOOP_EN
    test_len0();
    test_loop();
`else
    test_play();
    test_rest_skip();
    test_stop();
    test_write_while_busy();
    test_len0();
    test_async_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
